gpif_read_checker: RTL
======================

Name: gpif_read_checker

Overview:
- Streams 32-bit words out of the FX3 GPIF II slave FIFO (host-to-device direction) and checks them against an incrementing-counter pattern.
- It is the receive-side counterpart of the counter-streaming writer and consumes the loopback of what that writer produced.
- Alternates between two consumer threads, one buffer at a time, and exposes error and status information on the LEDs.

Parameters:
- BUFFER_WORDS, 4096: words per DMA buffer; thread switch after each buffer; power of two, 2..65536.
- READ_LATENCY, 2: PCLK cycles from a sampled-low RD_n to valid DQ; range 1..4.
- ERR_WIDTH, 16: width of the saturating error counter.

Ports:
- PCLK  input  1  GPIF clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- DQ  input  32  GPIF data bus from FX3.
- DMA2_Ready  input  1  thread 2 has a full buffer to read (active high).
- DMA3_Ready  input  1  thread 3 has a full buffer to read (active high).
- RD_n  output  1  read strobe, active low.
- OE_n  output  1  FX3 output enable, active low.
- SelectDMA  output  1  thread select: 0 = thread 2, 1 = thread 3.
- Locked  output  1  first valid word received since reset.
- ErrorCount  output  ERR_WIDTH  saturating mismatch count.
- LED  output  8  status, active low.

Behaviour:
- Reset values: RD_n=1, OE_n=1, SelectDMA=0, Locked=0, ErrorCount=0, Expected=0, WordCnt=0, valid pipe=0, state=IDLE.
- State IDLE: lasts one cycle so that SelectDMA is stable, then goes to WAIT.
- State WAIT: OE_n=1, RD_n=1. Samples the selected ready flag (SelectDMA ? DMA3_Ready : DMA2_Ready).
  - If set: go to READ, and drive OE_n=0 on entry.
  - The flag is sampled only in WAIT.
- State READ: OE_n=0, RD_n=0 for exactly BUFFER_WORDS consecutive cycles, counted by WordCnt.
  - On the last read cycle, RD_n is registered 1 for the next cycle and the state goes to DRAIN.
  - Changes on the ready flags during READ are ignored.
- State DRAIN: OE_n stays 0 for READ_LATENCY cycles, so that the last words land.
  - Then SelectDMA toggles, OE_n=1, and the state goes to WAIT.
  - Any other state encoding returns to IDLE.
- Valid pipe: a READ_LATENCY-deep shift register loaded with !RD_n. The tail bit marks DQ as valid in that cycle.
  - Exactly BUFFER_WORDS valid cycles occur per buffer.
- Checker, on each valid cycle:
  - If Locked=0: set Locked=1 and Expected<=DQ+1. No comparison is made on this seed word.
  - Else if DQ==Expected: Expected<=Expected+1.
  - Else: ErrorCount increments, saturating at all-ones, and Expected is updated per the optional feature.
- Expected wraps modulo 2^32 (0xFFFFFFFF is followed by 0x00000000, and this is not an error).
- LED[7] = ~Locked; LED[6] = ~(ErrorCount!=0); LED[5:0] = ~Expected[31:26].
- A RESET asserted at any point, including mid-READ, forces all reset values on the next edge.
  - RD_n and OE_n deassert immediately; words in flight in the pipe are discarded.

Optional Feature:
- Macro CHECKER_RESYNC_EN.
- Defined: on a mismatch, Expected<=DQ+1. A single dropped or inserted word costs exactly one error.
- Undefined: on a mismatch, Expected<=Expected+1. The checker keeps its own sequence, so a slip produces an error on every following word until the data realigns.

Test Plan:
- Reset, then DMA2_Ready=1 with DQ=0,1,2… (BUFFER_WORDS=16, READ_LATENCY=2) -> RD_n low for exactly 16 cycles; SelectDMA goes 0->1 two cycles after RD_n rises; Locked=1; ErrorCount=0.
- Both ready flags low -> the block stays in WAIT with RD_n=1 and OE_n=1 indefinitely. Then raise only DMA2_Ready while SelectDMA=1 -> no read starts. Raising DMA3_Ready -> the read starts.
- Stream through 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 -> ErrorCount=0 and Expected=0x2.
- Inject 5,6,8,9 after a correct 4 -> with CHECKER_RESYNC_EN ErrorCount=1; without it ErrorCount=2 after 9.
- Force 70000 mismatching words with ERR_WIDTH=16 -> ErrorCount holds at 0xFFFF.
- Assert RESET on the 7th read cycle -> next edge gives RD_n=1, OE_n=1, SelectDMA=0, Locked=0, ErrorCount=0; the pipe is empty, so no stray valid cycle follows.

Source files
------------

// File: rtl/gpif_read_checker.sv
`timescale 1ns/1ps
// gpif_read_checker: drains FX3 slave-FIFO buffers alternately from threads 2 and 3 and checks them
// against an incrementing 32-bit counter. Optional macro CHECKER_RESYNC_EN re-seeds after a mismatch.
module gpif_read_checker #(
    parameter int BUFFER_WORDS = 4096,
    parameter int READ_LATENCY = 2,
    parameter int ERR_WIDTH    = 16
) (
    input  logic                 PCLK,
    input  logic                 RESET,
    input  logic [31:0]          DQ,
    input  logic                 DMA2_Ready,
    input  logic                 DMA3_Ready,
    output logic                 RD_n,
    output logic                 OE_n,
    output logic                 SelectDMA,
    output logic                 Locked,
    output logic [ERR_WIDTH-1:0] ErrorCount,
    output logic [7:0]           LED
);

    localparam int CNT_W = (BUFFER_WORDS > 1) ? $clog2(BUFFER_WORDS) : 1;
    localparam int DRN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(BUFFER_WORDS - 1);
    localparam logic [DRN_W-1:0] LAST_DRAIN = DRN_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, READ, DRAIN} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        word_cnt;
    logic [CNT_W-1:0]        word_cnt_next;
    logic [DRN_W-1:0]        drain_cnt;
    logic [DRN_W-1:0]        drain_cnt_next;
    logic                    rd_n_next;
    logic                    oe_n_next;
    logic                    select_next;
    logic                    ready_sel;
    logic [READ_LATENCY-1:0] valid_pipe;
    logic [READ_LATENCY-1:0] pipe_next;
    logic                    word_valid;
    logic [31:0]             expected;

    assign ready_sel  = SelectDMA ? DMA3_Ready : DMA2_Ready;
    assign word_valid = valid_pipe[READ_LATENCY-1];

    // Strobes and thread select are registered so the FX3 sees glitch-free pins.
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state     <= IDLE;
            word_cnt  <= '0;
            drain_cnt <= '0;
            RD_n      <= 1'b1;
            OE_n      <= 1'b1;
            SelectDMA <= 1'b0;
        end else begin
            state     <= state_next;
            word_cnt  <= word_cnt_next;
            drain_cnt <= drain_cnt_next;
            RD_n      <= rd_n_next;
            OE_n      <= oe_n_next;
            SelectDMA <= select_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = WAIT;
            WAIT:    if (ready_sel) state_next = READ;
            READ:    if (word_cnt == LAST_WORD) state_next = DRAIN;
            DRAIN:   if (drain_cnt == LAST_DRAIN) state_next = WAIT;
            default: state_next = IDLE;
        endcase
    end

    // OE_n is held through DRAIN so the words still in the FX3 read pipeline can land.
    always_comb begin
        rd_n_next      = 1'b1;
        oe_n_next      = 1'b1;
        select_next    = SelectDMA;
        word_cnt_next  = '0;
        drain_cnt_next = '0;
        case (state)
            WAIT: begin
                if (ready_sel) begin
                    rd_n_next = 1'b0;
                    oe_n_next = 1'b0;
                end
            end
            READ: begin
                oe_n_next = 1'b0;
                if (word_cnt != LAST_WORD) begin
                    rd_n_next     = 1'b0;
                    word_cnt_next = word_cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == LAST_DRAIN) begin
                    select_next = ~SelectDMA;
                end else begin
                    oe_n_next      = 1'b0;
                    drain_cnt_next = drain_cnt + DRN_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pipe_next    = valid_pipe << 1;
        pipe_next[0] = ~RD_n;
    end

    always_ff @(posedge PCLK) begin
        if (RESET) begin
            valid_pipe <= '0;
            Locked     <= 1'b0;
            ErrorCount <= '0;
            expected   <= '0;
        end else begin
            valid_pipe <= pipe_next;
            if (word_valid) begin
                if (!Locked) begin
                    Locked   <= 1'b1;
                    expected <= DQ + 32'd1;
                end else if (DQ == expected) begin
                    expected <= expected + 32'd1;
                end else begin
                    if (ErrorCount != '1) ErrorCount <= ErrorCount + ERR_WIDTH'(1);
`ifdef CHECKER_RESYNC_EN
                    expected <= DQ + 32'd1;
`else
                    expected <= expected + 32'd1;
`endif
                end
            end
        end
    end

    assign LED = {~Locked, ~(ErrorCount != '0), ~expected[31:26]};

endmodule
